// File: rtl/score_display_pkg.sv
// Shared definitions for the score display: segment codes, conversion FSM states
// and the double-dabble nibble adjust helper.
package score_display_pkg;

  localparam int BCD_W = 12;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}, dp held off
  localparam logic [7:0] SEG_TABLE [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  function automatic logic [7:0] seg7_decode(input logic [3:0] digit);
    logic [7:0] seg_v;
    if (digit <= 4'd9) begin
      seg_v = SEG_TABLE[digit];
    end else begin
      seg_v = SEG_BLANK;
    end
    return seg_v;
  endfunction

  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res_v;
    logic [3:0]       nib_v;
    res_v = '0;
    for (int i = 0; i < BCD_W / 4; i++) begin
      nib_v = acc[4*i +: 4];
      if (nib_v >= 4'd5) begin
        res_v[4*i +: 4] = nib_v + 4'd3;
      end else begin
        res_v[4*i +: 4] = nib_v;
      end
    end
    return res_v;
  endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock. The bcd output
// only changes in DONE, so it always holds a complete conversion.
module bin2bcd_seq
  import score_display_pkg::*;
#(
  parameter int W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     bin,
  input  logic             start,
  output logic [BCD_W-1:0] bcd,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  conv_state_e      state_r;
  conv_state_e      state_s;
  logic [W-1:0]     sreg_r;
  logic [BCD_W-1:0] acc_r;
  logic [BCD_W-1:0] acc_adj_s;
  logic [BCD_W-1:0] bcd_r;
  logic [CNT_W-1:0] bit_cnt_r;

  assign acc_adj_s = dd_adjust(acc_r);

  // Conversion state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt_r == LAST_BIT) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Shift register, BCD accumulator and committed result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_r    <= '0;
      acc_r     <= '0;
      bcd_r     <= '0;
      bit_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            sreg_r    <= bin;
            acc_r     <= '0;
            bit_cnt_r <= '0;
          end
        end
        SHIFT: begin
          {acc_r, sreg_r} <= {acc_adj_s, sreg_r} << 1;
          bit_cnt_r       <= bit_cnt_r + CNT_W'(1);
        end
        DONE:    bcd_r <= acc_r;
        default: bcd_r <= bcd_r;
      endcase
    end
  end

  assign bcd  = bcd_r;
  assign busy = (state_r != IDLE);
  assign done = (state_r == DONE);

endmodule

// File: rtl/score_display.sv
// Shows the running score in decimal on a 4-digit multiplexed 7-segment display,
// blinking the whole display once the game is over.
module score_display
  import score_display_pkg::*;
#(
  parameter int SCORE_W = 9,
  parameter int SCAN_W  = 17,
  parameter int BLINK_W = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] newscore,
  input  logic               isover,
  output logic [3:0]         an,
  output logic [7:0]         seg,
  output logic               busy
);

  logic [SCORE_W-1:0] last_score_r;
  logic [SCORE_W-1:0] cap_r;
  logic [SCAN_W-1:0]  scan_cnt_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic [3:0]         an_r;
  logic [7:0]         seg_r;

  logic               start_s;
  logic               busy_s;
  logic               done_s;
  logic [BCD_W-1:0]   bcd_s;
  logic [1:0]         digit_sel_s;
  logic [3:0]         hund_s;
  logic [3:0]         tens_s;
  logic [3:0]         units_s;
  logic [3:0]         an_scan_s;
  logic [3:0]         an_s;
  logic [7:0]         seg_s;

  assign start_s = (newscore != last_score_r);

  bin2bcd_seq #(
    .W (SCORE_W)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .bin   (newscore),
    .start (start_s),
    .bcd   (bcd_s),
    .busy  (busy_s),
    .done  (done_s)
  );

  // last_score only advances on commit, so a change seen mid-conversion restarts from IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_r        <= '0;
      last_score_r <= '0;
    end else begin
      if (start_s && !busy_s) begin
        cap_r <= newscore;
      end
      if (done_s) begin
        last_score_r <= cap_r;
      end
    end
  end

  // Free-running scan and blink counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_r  <= '0;
      blink_cnt_r <= '0;
    end else begin
      scan_cnt_r  <= scan_cnt_r + SCAN_W'(1);
      blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
    end
  end

  assign digit_sel_s = scan_cnt_r[SCAN_W-1 -: 2];
  assign hund_s      = bcd_s[11:8];
  assign tens_s      = bcd_s[7:4];
  assign units_s     = bcd_s[3:0];

  // Digit select with leading-zero suppression
  always_comb begin
    an_scan_s = 4'hF;
    seg_s     = SEG_BLANK;
    case (digit_sel_s)
      2'd0: begin
        an_scan_s = 4'b1110;
        seg_s     = seg7_decode(units_s);
      end
      2'd1: begin
        if ((hund_s != 4'd0) || (tens_s != 4'd0)) begin
          an_scan_s = 4'b1101;
          seg_s     = seg7_decode(tens_s);
        end else begin
          an_scan_s = 4'hF;
          seg_s     = SEG_BLANK;
        end
      end
      2'd2: begin
        if (hund_s != 4'd0) begin
          an_scan_s = 4'b1011;
          seg_s     = seg7_decode(hund_s);
        end else begin
          an_scan_s = 4'hF;
          seg_s     = SEG_BLANK;
        end
      end
      default: begin
        an_scan_s = 4'hF;
        seg_s     = SEG_BLANK;
      end
    endcase
  end

  // Blink only gates the anodes; segments keep the scanned digit
  always_comb begin
    if (isover && blink_cnt_r[BLINK_W-1]) begin
      an_s = 4'hF;
    end else begin
      an_s = an_scan_s;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r  <= 4'hF;
      seg_r <= SEG_BLANK;
    end else begin
      an_r  <= an_s;
      seg_r <= seg_s;
    end
  end

  assign an   = an_r;
  assign seg  = seg_r;
  assign busy = busy_s;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a cycle-level behavioural model of the
// displayed score, scan position and blink phase.
module tb_score_display;

  localparam int SCORE_W = 9;
  localparam int SCAN_W  = 4;
  localparam int BLINK_W = 6;
  localparam int CONV_CYCLES = SCORE_W + 1;

  logic               clk;
  logic               rst_n;
  logic [SCORE_W-1:0] newscore;
  logic               isover;
  logic [3:0]         an;
  logic [7:0]         seg;
  logic               busy;

  int total;
  int bad;

  score_display #(
    .SCORE_W (SCORE_W),
    .SCAN_W  (SCAN_W),
    .BLINK_W (BLINK_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .newscore (newscore),
    .isover   (isover),
    .an       (an),
    .seg      (seg),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'hF8 ^ 8'h7A, 8'hF8, 8'h80, 8'h90};

  // Model state: the value on the display, a pending conversion's countdown,
  // and the scan/blink positions.
  int         m_last, m_cap, m_cnt, m_disp, m_scan, m_blink, m_d;
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic       exp_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = 0; m_cap = 0; m_cnt = 0; m_disp = 0; m_scan = 0; m_blink = 0;
      exp_an = 4'hF; exp_seg = 8'hFF; exp_busy = 1'b0;
    end else begin
      m_d = m_scan >> (SCAN_W - 2);
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
      if (m_d == 0) begin
        exp_an = 4'b1110; exp_seg = seg_tab[m_disp % 10];
      end else if (m_d == 1 && m_disp >= 10) begin
        exp_an = 4'b1101; exp_seg = seg_tab[(m_disp / 10) % 10];
      end else if (m_d == 2 && m_disp >= 100) begin
        exp_an = 4'b1011; exp_seg = seg_tab[m_disp / 100];
      end
      if (isover && m_blink >= (1 << (BLINK_W - 1))) exp_an = 4'hF;
      if (m_cnt == 0) begin
        if (int'(newscore) != m_last) begin
          m_cap = int'(newscore);
          m_cnt = CONV_CYCLES;
        end
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_disp = m_cap;
          m_last = m_cap;
        end
      end
      exp_busy = (m_cnt != 0);
      m_scan   = (m_scan + 1) % (1 << SCAN_W);
      m_blink  = (m_blink + 1) % (1 << BLINK_W);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    total++;
    if (an !== exp_an) begin
      bad++;
      $display("FAIL model_an t=%0t got=%b exp=%b", $time, an, exp_an);
    end
    total++;
    if (seg !== exp_seg) begin
      bad++;
      $display("FAIL model_seg t=%0t got=%h exp=%h", $time, seg, exp_seg);
    end
    total++;
    if (busy !== exp_busy) begin
      bad++;
      $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, exp_busy);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  logic [7:0] seg_u, seg_t, seg_h;
  logic       seen_u, seen_t, seen_h, seen_3, seen_busy;

  task automatic scan_capture();
    seen_u = 1'b0; seen_t = 1'b0; seen_h = 1'b0; seen_3 = 1'b0; seen_busy = 1'b0;
    seg_u = 8'hFF; seg_t = 8'hFF; seg_h = 8'hFF;
    for (int i = 0; i < (1 << SCAN_W); i++) begin
      @(negedge clk);
      #1;
      if (busy) seen_busy = 1'b1;
      case (an)
        4'b1110: begin seg_u = seg; seen_u = 1'b1; end
        4'b1101: begin seg_t = seg; seen_t = 1'b1; end
        4'b1011: begin seg_h = seg; seen_h = 1'b1; end
        default: if (an[3] == 1'b0) seen_3 = 1'b1;
      endcase
    end
  endtask

  task automatic wait_bcd(input string name, input logic [11:0] target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (dut.bcd_s == target) hit = 1'b1;
    end
    check(name, {31'd0, hit}, 32'd1);
  endtask

  task automatic count_off(output int n);
    n = 0;
    for (int i = 0; i < (1 << BLINK_W); i++) begin
      @(negedge clk);
      #1;
      if (an == 4'hF) n++;
    end
  endtask

  int busy_cycles, off_cnt;

  initial begin
    total = 0;
    bad = 0;
    seg_tab[6] = 8'h82;
    rst_n = 1'b0;
    newscore = 9'd0;
    isover = 1'b0;
    step(3);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {24'd0, seg}, 32'hFF);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // 1: score 0 shows a lone "0" in the units digit
    step(4);
    scan_capture();
    check("t1_units", {24'd0, seg_u}, 32'hC0);
    check("t1_units_seen", {31'd0, seen_u}, 32'd1);
    check("t1_tens_blank", {31'd0, seen_t}, 32'd0);
    check("t1_hund_blank", {31'd0, seen_h}, 32'd0);
    check("t1_busy_idle", {31'd0, seen_busy}, 32'd0);

    // 2: 0 -> 138, result commits on edge 11
    newscore = 9'd138;
    busy_cycles = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cycles++;
      if (k == 10) check("t2_bcd_edge10", {20'd0, dut.bcd_s}, 32'h000);
      if (k == 11) check("t2_bcd_edge11", {20'd0, dut.bcd_s}, 32'h138);
    end
    check("t2_busy_cycles", busy_cycles, 32'd10);
    step(2);
    scan_capture();
    check("t2_units", {24'd0, seg_u}, 32'h80);
    check("t2_tens", {24'd0, seg_t}, 32'hB0);
    check("t2_hund", {24'd0, seg_h}, 32'hF9);
    check("t2_digit3_blank", {31'd0, seen_3}, 32'd0);

    // 3: change during conversion is picked up after the first commit
    newscore = 9'd5;
    step(4);
    newscore = 9'd7;
    wait_bcd("t3_first_005", 12'h005);
    wait_bcd("t3_final_007", 12'h007);
    step(2);
    scan_capture();
    check("t3_units", {24'd0, seg_u}, 32'hF8);
    check("t3_tens_blank", {31'd0, seen_t}, 32'd0);
    check("t3_hund_blank", {31'd0, seen_h}, 32'd0);

    // 4: maximum score and an internal zero digit
    newscore = 9'd511;
    step(14);
    scan_capture();
    check("t4_511_units", {24'd0, seg_u}, 32'hF9);
    check("t4_511_tens", {24'd0, seg_t}, 32'hF9);
    check("t4_511_hund", {24'd0, seg_h}, 32'h92);
    newscore = 9'd100;
    step(14);
    scan_capture();
    check("t4_100_units", {24'd0, seg_u}, 32'hC0);
    check("t4_100_tens", {24'd0, seg_t}, 32'hC0);
    check("t4_100_tens_seen", {31'd0, seen_t}, 32'd1);
    check("t4_100_hund", {24'd0, seg_h}, 32'hF9);

    // 5: blink over one full blink period, then steady again
    newscore = 9'd138;
    step(14);
    isover = 1'b1;
    step(2);
    count_off(off_cnt);
    check("t5_blink_off", off_cnt, 32'd40);
    isover = 1'b0;
    step(2);
    count_off(off_cnt);
    check("t5_steady_off", off_cnt, 32'd16);

    // 6: reset in the middle of a conversion
    newscore = 9'd300;
    step(3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_an", {28'd0, an}, 32'hF);
    check("t6_rst_seg", {24'd0, seg}, 32'hFF);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_bcd", {20'd0, dut.bcd_s}, 32'h000);
    step(2);
    rst_n = 1'b1;
    step(14);
    check("t6_bcd_300", {20'd0, dut.bcd_s}, 32'h300);
    scan_capture();
    check("t6_units", {24'd0, seg_u}, 32'hC0);
    check("t6_tens", {24'd0, seg_t}, 32'hC0);
    check("t6_hund", {24'd0, seg_h}, 32'hB0);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
